usc_rv_iq: RTL and testbench

In-order, dual-write, dual-read issue queue directly downstream of the two-lane RV decode stage. Each cycle it accepts up to two decoded op-control words (lane 0 older than lane 1) and presents the two oldest entries to the execute/issue logic. Backpressure to decode is the `stall_de` pair, computed only from registered occupancy. Program order is preserved end to end, and `core_flush` empties the queue.

---
 rtl/usc_rv_iq.sv | 124 ++++++++++++
 tb/tb_usc_rv_iq.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/usc_rv_iq.sv
// usc_rv_iq: in-order dual-write / dual-read issue queue placed after the
// two-lane decode stage. Occupancy, pointers and the entry array are the only
// state; entry validity is derived from the occupancy counter alone.

module usc_rv_iq #(
    parameter int DEPTH = 8,
    parameter int CTL_W = 64,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             core_flush,
    input  logic             op0_dec_v_i,
    input  logic [CTL_W-1:0] op0_dec_ctl_i,
    input  logic             op1_dec_v_i,
    input  logic [CTL_W-1:0] op1_dec_ctl_i,
    output logic [1:0]       stall_de_o,
    output logic             iss0_v_o,
    output logic [CTL_W-1:0] iss0_ctl_o,
    input  logic             iss0_rdy_i,
    output logic             iss1_v_o,
    output logic [CTL_W-1:0] iss1_ctl_o,
    input  logic             iss1_rdy_i,
    output logic [CNT_W-1:0] iq_cnt_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic [CTL_W-1:0] r_mem [DEPTH];

    logic [CNT_W-1:0] w_free;
    logic             w_acc0;
    logic             w_acc1;
    logic             w_pop0;
    logic             w_pop1;
    logic [PTR_W-1:0] w_wr_addr1;
    logic [PTR_W-1:0] w_rd_addr1;
    logic [CNT_W-1:0] w_cnt_next;

    // Backpressure, validity, accept/pop qualification and next occupancy.
    // Stall and valid depend on registered occupancy only, so there is no
    // combinational path from the valid/ready inputs to them.
    always_comb begin
        w_free     = CNT_W'(DEPTH) - r_cnt;
        stall_de_o = {(w_free < CNT_W'(2)), (w_free < CNT_W'(1))};
        iss0_v_o   = (r_cnt >= CNT_W'(1));
        iss1_v_o   = (r_cnt >= CNT_W'(2));
        w_acc0     = op0_dec_v_i & ~stall_de_o[0];
        w_acc1     = op1_dec_v_i & ~stall_de_o[1];
        w_pop0     = iss0_v_o & iss0_rdy_i;
        // Slot 1 only leaves together with slot 0 to keep issue in order.
        w_pop1     = w_pop0 & iss1_v_o & iss1_rdy_i;
        // A lone lane-1 op lands at wr_ptr, behind lane 0 otherwise.
        w_wr_addr1 = r_wr_ptr + PTR_W'(w_acc0);
        w_rd_addr1 = r_rd_ptr + PTR_W'(1'b1);
        w_cnt_next = r_cnt + CNT_W'(w_acc0) + CNT_W'(w_acc1)
                   - CNT_W'(w_pop0) - CNT_W'(w_pop1);
        iss0_ctl_o = r_mem[r_rd_ptr];
        iss1_ctl_o = r_mem[w_rd_addr1];
        iq_cnt_o   = r_cnt;
    end

    // Pointer and occupancy state; flush empties the queue and rewinds both pointers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr <= {PTR_W{1'b0}};
            r_wr_ptr <= {PTR_W{1'b0}};
            r_cnt    <= {CNT_W{1'b0}};
        end else if (core_flush) begin
            r_rd_ptr <= {PTR_W{1'b0}};
            r_wr_ptr <= {PTR_W{1'b0}};
            r_cnt    <= {CNT_W{1'b0}};
        end else begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop0) + PTR_W'(w_pop1);
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_acc0) + PTR_W'(w_acc1);
            r_cnt    <= w_cnt_next;
        end
    end

    // Entry array writes; not reset since validity comes from occupancy.
    always_ff @(posedge clk) begin
        if (!core_flush) begin
            if (w_acc0) begin
                r_mem[r_wr_ptr] <= op0_dec_ctl_i;
            end
            if (w_acc1) begin
                r_mem[w_wr_addr1] <= op1_dec_ctl_i;
            end
        end
    end

    usc_rv_iq_chk #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_chk (
        .clk     (clk),
        .reset_n (reset_n),
        .cnt     (r_cnt),
        .stall   (stall_de_o)
    );

endmodule

// Occupancy invariants of the issue queue.
module usc_rv_iq_chk #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
) (
    input logic             clk,
    input logic             reset_n,
    input logic [CNT_W-1:0] cnt,
    input logic [1:0]       stall
);

    a_cnt_bound: assert property (@(posedge clk) disable iff (!reset_n)
        cnt <= CNT_W'(DEPTH));

    a_stall_order: assert property (@(posedge clk) disable iff (!reset_n)
        stall[0] |-> stall[1]);

endmodule

// File: tb/tb_usc_rv_iq.sv
// Directed testbench for usc_rv_iq (DEPTH=8, CTL_W=64).

module tb_usc_rv_iq;

    localparam int DEPTH = 8;
    localparam int CTL_W = 64;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             core_flush = 1'b0;
    logic             op0_dec_v_i = 1'b0;
    logic [CTL_W-1:0] op0_dec_ctl_i = '0;
    logic             op1_dec_v_i = 1'b0;
    logic [CTL_W-1:0] op1_dec_ctl_i = '0;
    logic [1:0]       stall_de_o;
    logic             iss0_v_o;
    logic [CTL_W-1:0] iss0_ctl_o;
    logic             iss0_rdy_i = 1'b0;
    logic             iss1_v_o;
    logic [CTL_W-1:0] iss1_ctl_o;
    logic             iss1_rdy_i = 1'b0;
    logic [CNT_W-1:0] iq_cnt_o;

    int errors = 0;
    int checks = 0;

    usc_rv_iq #(.DEPTH(DEPTH), .CTL_W(CTL_W)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .core_flush    (core_flush),
        .op0_dec_v_i   (op0_dec_v_i),
        .op0_dec_ctl_i (op0_dec_ctl_i),
        .op1_dec_v_i   (op1_dec_v_i),
        .op1_dec_ctl_i (op1_dec_ctl_i),
        .stall_de_o    (stall_de_o),
        .iss0_v_o      (iss0_v_o),
        .iss0_ctl_o    (iss0_ctl_o),
        .iss0_rdy_i    (iss0_rdy_i),
        .iss1_v_o      (iss1_v_o),
        .iss1_ctl_o    (iss1_ctl_o),
        .iss1_rdy_i    (iss1_rdy_i),
        .iq_cnt_o      (iq_cnt_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running required finished");
        $fatal(1);
    end

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        op0_dec_v_i = 1'b0;
        op1_dec_v_i = 1'b0;
        iss0_rdy_i  = 1'b0;
        iss1_rdy_i  = 1'b0;
        core_flush  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        #1;
    endtask

    // One write cycle with no pops.
    task automatic push(input logic v0, input logic [CTL_W-1:0] c0,
                        input logic v1, input logic [CTL_W-1:0] c1);
        op0_dec_v_i = v0; op0_dec_ctl_i = c0;
        op1_dec_v_i = v1; op1_dec_ctl_i = c1;
        step();
        idle_inputs();
    endtask

    // One pop cycle with no writes.
    task automatic pop(input logic r0, input logic r1);
        iss0_rdy_i = r0; iss1_rdy_i = r1;
        step();
        idle_inputs();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #1;
        checks++;
        if (iq_cnt_o !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d required 0", iq_cnt_o); end
        checks++;
        if ({iss0_v_o, iss1_v_o} !== 2'b00) begin errors++; $display("FAIL reset_valid: got %b required 00", {iss0_v_o, iss1_v_o}); end
        checks++;
        if (stall_de_o !== 2'b00) begin errors++; $display("FAIL reset_stall: got %b required 00", stall_de_o); end
        reset_n = 1'b1;
    endtask

    task automatic test_dual_write();
        do_reset();
        push(1'b1, 64'hAAAA_0000_0000_000A, 1'b1, 64'hBBBB_0000_0000_000B);
        checks++;
        if (iss0_ctl_o !== 64'hAAAA_0000_0000_000A) begin errors++; $display("FAIL dual_iss0_ctl: got %h required %h", iss0_ctl_o, 64'hAAAA_0000_0000_000A); end
        checks++;
        if (iss1_ctl_o !== 64'hBBBB_0000_0000_000B) begin errors++; $display("FAIL dual_iss1_ctl: got %h required %h", iss1_ctl_o, 64'hBBBB_0000_0000_000B); end
        checks++;
        if ({iss0_v_o, iss1_v_o} !== 2'b11) begin errors++; $display("FAIL dual_valid: got %b required 11", {iss0_v_o, iss1_v_o}); end
        checks++;
        if (iq_cnt_o !== 4'd2) begin errors++; $display("FAIL dual_cnt: got %0d required 2", iq_cnt_o); end
        pop(1'b1, 1'b1);
        checks++;
        if (iq_cnt_o !== 4'd0) begin errors++; $display("FAIL dual_drain_cnt: got %0d required 0", iq_cnt_o); end
    endtask

    task automatic test_lone_op1();
        do_reset();
        push(1'b0, 64'h0, 1'b1, 64'hCCCC_0000_0000_000C);
        checks++;
        if (iq_cnt_o !== 4'd1) begin errors++; $display("FAIL lone_cnt: got %0d required 1", iq_cnt_o); end
        checks++;
        if ({iss0_v_o, iss1_v_o} !== 2'b10) begin errors++; $display("FAIL lone_valid: got %b required 10", {iss0_v_o, iss1_v_o}); end
        checks++;
        if (iss0_ctl_o !== 64'hCCCC_0000_0000_000C) begin errors++; $display("FAIL lone_iss0_ctl: got %h required %h", iss0_ctl_o, 64'hCCCC_0000_0000_000C); end
        push(1'b1, 64'hDDDD_0000_0000_000D, 1'b0, 64'h0);
        checks++;
        if (iss1_ctl_o !== 64'hDDDD_0000_0000_000D) begin errors++; $display("FAIL lone_next_slot: got %h required %h", iss1_ctl_o, 64'hDDDD_0000_0000_000D); end
    endtask

    task automatic test_fill_stall();
        logic [CTL_W-1:0] exp0, exp1;
        do_reset();
        for (int k = 0; k < 6; k += 2) begin
            push(1'b1, 64'hF000 + 64'(k), 1'b1, 64'hF000 + 64'(k + 1));
        end
        push(1'b1, 64'hF006, 1'b0, 64'h0);
        checks++;
        if (iq_cnt_o !== 4'd7) begin errors++; $display("FAIL fill_cnt7: got %0d required 7", iq_cnt_o); end
        checks++;
        if (stall_de_o !== 2'b10) begin errors++; $display("FAIL fill_stall7: got %b required 10", stall_de_o); end
        push(1'b1, 64'hF007, 1'b1, 64'hEEEE);
        checks++;
        if (iq_cnt_o !== 4'd8) begin errors++; $display("FAIL fill_cnt8: got %0d required 8", iq_cnt_o); end
        checks++;
        if (stall_de_o !== 2'b11) begin errors++; $display("FAIL fill_stall8: got %b required 11", stall_de_o); end
        push(1'b1, 64'h1111, 1'b1, 64'h2222);
        checks++;
        if (iq_cnt_o !== 4'd8) begin errors++; $display("FAIL full_hold_cnt: got %0d required 8", iq_cnt_o); end
        for (int k = 0; k < 8; k += 2) begin
            exp0 = 64'hF000 + 64'(k);
            exp1 = 64'hF000 + 64'(k + 1);
            checks++;
            if ({iss0_ctl_o, iss1_ctl_o} !== {exp0, exp1}) begin errors++; $display("FAIL fill_order_%0d: got %h/%h required %h/%h", k, iss0_ctl_o, iss1_ctl_o, exp0, exp1); end
            pop(1'b1, 1'b1);
        end
        checks++;
        if (iq_cnt_o !== 4'd0) begin errors++; $display("FAIL fill_drained: got %0d required 0", iq_cnt_o); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int k = 0; k < 7; k++) begin
            push(1'b1, 64'h7000 + 64'(k), 1'b0, 64'h0);
        end
        for (int k = 0; k < 3; k++) begin
            pop(1'b1, 1'b1);
        end
        pop(1'b1, 1'b0);
        checks++;
        if (iq_cnt_o !== 4'd0) begin errors++; $display("FAIL wrap_pre_cnt: got %0d required 0", iq_cnt_o); end
        push(1'b1, 64'hCAFE_0007, 1'b1, 64'hCAFE_0000);
        push(1'b1, 64'hCAFE_0001, 1'b1, 64'hCAFE_0002);
        checks++;
        if (iq_cnt_o !== 4'd4) begin errors++; $display("FAIL wrap_cnt4: got %0d required 4", iq_cnt_o); end
        checks++;
        if ({iss0_ctl_o, iss1_ctl_o} !== {64'hCAFE_0007, 64'hCAFE_0000}) begin errors++; $display("FAIL wrap_straddle: got %h/%h required cafe0007/cafe0000", iss0_ctl_o, iss1_ctl_o); end
        pop(1'b1, 1'b1);
        checks++;
        if (iq_cnt_o !== 4'd2) begin errors++; $display("FAIL wrap_cnt2: got %0d required 2", iq_cnt_o); end
        checks++;
        if ({iss0_ctl_o, iss1_ctl_o} !== {64'hCAFE_0001, 64'hCAFE_0002}) begin errors++; $display("FAIL wrap_after: got %h/%h required cafe0001/cafe0002", iss0_ctl_o, iss1_ctl_o); end
    endtask

    task automatic test_rdy_gating();
        do_reset();
        push(1'b1, 64'h6000, 1'b1, 64'h6001);
        push(1'b1, 64'h6002, 1'b1, 64'h6003);
        pop(1'b0, 1'b1);
        checks++;
        if (iq_cnt_o !== 4'd4) begin errors++; $display("FAIL gate_cnt: got %0d required 4", iq_cnt_o); end
        checks++;
        if (iss0_ctl_o !== 64'h6000) begin errors++; $display("FAIL gate_head: got %h required 6000", iss0_ctl_o); end
        pop(1'b1, 1'b1);
        checks++;
        if (iq_cnt_o !== 4'd2) begin errors++; $display("FAIL gate_pop2_cnt: got %0d required 2", iq_cnt_o); end
        checks++;
        if ({iss0_ctl_o, iss1_ctl_o} !== {64'h6002, 64'h6003}) begin errors++; $display("FAIL gate_pop2_ctl: got %h/%h required 6002/6003", iss0_ctl_o, iss1_ctl_o); end
        pop(1'b1, 1'b0);
        checks++;
        if ({iq_cnt_o, iss0_ctl_o} !== {4'd1, 64'h6003}) begin errors++; $display("FAIL gate_pop1: got %0d/%h required 1/6003", iq_cnt_o, iss0_ctl_o); end
    endtask

    task automatic test_flush();
        do_reset();
        push(1'b1, 64'h5000, 1'b1, 64'h5001);
        push(1'b1, 64'h5002, 1'b1, 64'h5003);
        push(1'b1, 64'h5004, 1'b0, 64'h0);
        op0_dec_v_i = 1'b1; op0_dec_ctl_i = 64'h5005;
        op1_dec_v_i = 1'b1; op1_dec_ctl_i = 64'h5006;
        iss0_rdy_i = 1'b1; iss1_rdy_i = 1'b1; core_flush = 1'b1;
        #1;
        checks++;
        if (stall_de_o !== 2'b00) begin errors++; $display("FAIL flush_cycle_stall: got %b required 00", stall_de_o); end
        step();
        idle_inputs();
        checks++;
        if (iq_cnt_o !== 4'd0) begin errors++; $display("FAIL flush_cnt: got %0d required 0", iq_cnt_o); end
        checks++;
        if (iss0_v_o !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b required 0", iss0_v_o); end
        checks++;
        if (stall_de_o !== 2'b00) begin errors++; $display("FAIL flush_stall: got %b required 00", stall_de_o); end
        push(1'b1, 64'h5A5A, 1'b0, 64'h0);
        checks++;
        if ({iq_cnt_o, iss0_ctl_o} !== {4'd1, 64'h5A5A}) begin errors++; $display("FAIL flush_restart: got %0d/%h required 1/5a5a", iq_cnt_o, iss0_ctl_o); end
    endtask

    task automatic test_async_reset();
        do_reset();
        push(1'b1, 64'h4000, 1'b1, 64'h4001);
        #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({iq_cnt_o, iss0_v_o, iss1_v_o} !== {4'd0, 2'b00}) begin errors++; $display("FAIL async_reset: got cnt=%0d v=%b%b required cnt=0 v=00", iq_cnt_o, iss0_v_o, iss1_v_o); end
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_dual_write();
        test_lone_op1();
        test_fill_stall();
        test_wrap();
        test_rdy_gating();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
